// File: rtl/clock_ctrl_if.sv
// clock_ctrl_if: front-panel button inputs and control outputs of the clock
// mode/time-set controller.
//   btn_mode, btn_inc : raw push-buttons, active-high, asynchronous
//   mode              : 0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC
//   sec_tick          : 1 Hz one-cycle pulse (RUN only)
//   inc_hr/min/sec    : one-cycle increment pulses to the BCD counters
//   blink             : display-blank enable for the field being set
// master = panel/counter side, slave = controller.
interface clock_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] mode;
  logic       sec_tick;
  logic       inc_hr;
  logic       inc_min;
  logic       inc_sec;
  logic       blink;

  modport master (
    output btn_mode, btn_inc,
    input  mode, sec_tick, inc_hr, inc_min, inc_sec, blink
  );

  modport slave (
    input  btn_mode, btn_inc,
    output mode, sec_tick, inc_hr, inc_min, inc_sec, blink
  );
endinterface

// File: rtl/clock_ctrl.sv
// clock_ctrl: mode and time-set controller for the 24-hour BCD clock.
// Synchronizes and debounces the two panel buttons, steps the four-state mode
// machine, generates sec_tick in RUN and issues increment pulses (with
// hold-to-repeat) in the set modes. Holds no time registers itself.
//   clk4m : 4 MHz system clock
//   clr   : synchronous active-high reset
//   bus   : clock_ctrl_if.slave (buttons in, mode/tick/inc/blink out)
module clock_ctrl #(
  parameter int unsigned TICK_DIV = 4000000,
  parameter int unsigned DEB_BITS = 16,
  parameter int unsigned REP_DLY  = 60,
  parameter int unsigned REP_RATE = 15
) (
  input  logic        clk4m,
  input  logic        clr,
  clock_ctrl_if.slave bus
);

  localparam int unsigned SAMP_W = DEB_BITS + 5;
  localparam int unsigned PRE_W  = $clog2(TICK_DIV);
  localparam int unsigned REP_W  = $clog2(REP_DLY + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [1:0]        bm_sync_q, bi_sync_q;
  logic              bm_smp_q, bm_smp_d, bi_smp_q, bi_smp_d;
  logic              bm_lvl_q, bm_lvl_d, bi_lvl_q, bi_lvl_d;
  logic              bm_lvl_dly_q, bi_lvl_dly_q;
  logic              sec_tick_q, sec_tick_d;
  logic              inc_hr_q, inc_hr_d;
  logic              inc_min_q, inc_min_d;
  logic              inc_sec_q, inc_sec_d;
  logic              blink_q, blink_d;

  logic              samp_c;
  logic              mode_rise_c;
  logic              inc_rise_c;
  logic              pulse_c;

  // State and output registers
  always_ff @(posedge clk4m) begin
    if (clr) begin
      mode_q       <= RUN;
      samp_cnt_q   <= '0;
      presc_q      <= '0;
      rep_q        <= '0;
      bm_sync_q    <= '0;
      bi_sync_q    <= '0;
      bm_smp_q     <= 1'b0;
      bi_smp_q     <= 1'b0;
      bm_lvl_q     <= 1'b0;
      bi_lvl_q     <= 1'b0;
      bm_lvl_dly_q <= 1'b0;
      bi_lvl_dly_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      inc_hr_q     <= 1'b0;
      inc_min_q    <= 1'b0;
      inc_sec_q    <= 1'b0;
      blink_q      <= 1'b1;
    end else begin
      mode_q       <= mode_d;
      samp_cnt_q   <= samp_cnt_d;
      presc_q      <= presc_d;
      rep_q        <= rep_d;
      bm_sync_q    <= {bm_sync_q[0], bus.btn_mode};
      bi_sync_q    <= {bi_sync_q[0], bus.btn_inc};
      bm_smp_q     <= bm_smp_d;
      bi_smp_q     <= bi_smp_d;
      bm_lvl_q     <= bm_lvl_d;
      bi_lvl_q     <= bi_lvl_d;
      bm_lvl_dly_q <= bm_lvl_q;
      bi_lvl_dly_q <= bi_lvl_q;
      sec_tick_q   <= sec_tick_d;
      inc_hr_q     <= inc_hr_d;
      inc_min_q    <= inc_min_d;
      inc_sec_q    <= inc_sec_d;
      blink_q      <= blink_d;
    end
  end

  // Debounce, mode sequencing, prescaler and increment generation
  always_comb begin
    samp_cnt_d = samp_cnt_q + SAMP_W'(1);
    bm_smp_d   = bm_smp_q;
    bi_smp_d   = bi_smp_q;
    bm_lvl_d   = bm_lvl_q;
    bi_lvl_d   = bi_lvl_q;
    mode_d     = mode_q;
    presc_d    = presc_q;
    rep_d      = rep_q;
    sec_tick_d = 1'b0;
    pulse_c    = 1'b0;

    samp_c      = &samp_cnt_q[DEB_BITS-1:0];
    mode_rise_c = bm_lvl_q & ~bm_lvl_dly_q;
    inc_rise_c  = bi_lvl_q & ~bi_lvl_dly_q;

    // Level flips only when this sample matches the previous one
    if (samp_c) begin
      bm_smp_d = bm_sync_q[1];
      bi_smp_d = bi_sync_q[1];
      if ((bm_sync_q[1] == bm_smp_q) && (bm_sync_q[1] != bm_lvl_q)) begin
        bm_lvl_d = bm_sync_q[1];
      end
      if ((bi_sync_q[1] == bi_smp_q) && (bi_sync_q[1] != bi_lvl_q)) begin
        bi_lvl_d = bi_sync_q[1];
      end
    end

    // Mode change wins over any increment in the same cycle
    if (mode_rise_c) begin
      case (mode_q)
        RUN:     mode_d = SET_HR;
        SET_HR:  mode_d = SET_MIN;
        SET_MIN: mode_d = SET_SEC;
        default: mode_d = RUN;
      endcase
      rep_d   = '0;
      presc_d = '0;
    end else if (mode_q == RUN) begin
      rep_d = '0;
      if (presc_q == PRE_W'(TICK_DIV - 1)) begin
        presc_d    = '0;
        sec_tick_d = 1'b1;
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end else begin
      presc_d = '0;
      pulse_c = inc_rise_c;
      if (!bi_lvl_q) begin
        rep_d = '0;
      end else if (samp_c) begin
        // Reload keeps subsequent repeats REP_RATE samples apart
        if (rep_q == REP_W'(REP_DLY - 1)) begin
          pulse_c = 1'b1;
          rep_d   = REP_W'(REP_DLY - REP_RATE);
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end
    end

    inc_hr_d  = pulse_c && (mode_q == SET_HR);
    inc_min_d = pulse_c && (mode_q == SET_MIN);
    inc_sec_d = pulse_c && (mode_q == SET_SEC);
    // Registered copy of (RUN or counter MSB) using next-state values
    blink_d   = (mode_d == RUN) | samp_cnt_d[SAMP_W-1];
  end

  assign bus.mode     = mode_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.inc_hr   = inc_hr_q;
  assign bus.inc_min  = inc_min_q;
  assign bus.inc_sec  = inc_sec_q;
  assign bus.blink    = blink_q;

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Mode and time-set controller for the 24-hour BCD clock. Runs from `clk4m` and conditions the raw `btn_mode` and `btn_inc` push-buttons: two-flop synchronizer, then sampled debounce. Sequences a four-state mode machine, generates the 1 Hz `sec_tick` in RUN, and issues single-cycle increment pulses (with hold-to-repeat) to the hour, minute and second counters in the set modes. Sits between the front-panel buttons and the BCD counter chain; it contains no time registers itself.

## Interface
- `TICK_DIV`, 4000000, `clk4m` cycles per `sec_tick`; minimum 2.
- `DEB_BITS`, 16, sample strobe every 2^DEB_BITS cycles (≈16.4 ms); minimum 2.
- `REP_DLY`, 60, sample periods `btn_inc` must be held before auto-repeat starts.
- `REP_RATE`, 15, sample periods between repeat pulses.
- `clk4m` input 1, system clock, 4 MHz.
- `clr` input 1, reset, synchronous and active-high.
- `btn_mode` input 1, raw mode button, active-high, asynchronous to `clk4m`.
- `btn_inc` input 1, raw increment button, active-high, asynchronous.
- `mode` output 2, 0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC.
- `sec_tick` output 1, one-cycle pulse per second, RUN only.
- `inc_hr` output 1, one-cycle increment pulse to the hour counter.
- `inc_min` output 1, one-cycle increment pulse to the minute counter.
- `inc_sec` output 1, one-cycle increment pulse to the second counter.
- `blink` output 1, display-blank enable for the field being set.

## Operation
- Reset values: `mode`=0, all pulse outputs 0, `blink`=1. Prescaler, sample counter, repeat counter, synchronizer flops and debounced levels are all 0.
- Sample counter:
  - Free-running, DEB_BITS+5 bits.
  - `samp` is a one-cycle strobe when the low DEB_BITS bits are all ones.
- Debounce:
  - Each button is sampled on `samp`.
  - The debounced level changes only when two consecutive samples agree and differ from the current level.
  - A rising edge of the debounced level produces an internal one-cycle `*_rise`.
- Mode FSM:
  - On `mode_rise`: RUN→SET_HR→SET_MIN→SET_SEC→RUN.
  - No other transitions.
- Increment:
  - In SET_x, `inc_rise` asserts the matching `inc_*`.
  - In RUN, `btn_inc` is ignored and the repeat counter is held at 0.
- Auto-repeat:
  - While the debounced `btn_inc` is 1 in a SET state, the repeat counter advances on each `samp`.
  - When the count reaches REP_DLY, one pulse is issued and the counter reloads to REP_DLY−REP_RATE.
  - Result: further pulses every REP_RATE samples.
  - Release clears the counter.
- Prescaler:
  - In RUN, counts 0..TICK_DIV−1 and wraps; `sec_tick` pulses on the wrap.
  - In any SET state, the prescaler is held at 0 and `sec_tick` is 0, so seconds realign on exit.
- Blink:
  - `blink` = 1 in RUN.
  - In SET states, `blink` = MSB of the sample counter (period 2^(DEB_BITS+5) cycles, ≈0.52 s at defaults).
- Simultaneous events:
  - If `mode_rise` and `inc_rise` occur in the same cycle, the mode change wins and no `inc_*` is issued.
  - The repeat counter clears on every mode change.
- At most one of `inc_hr`/`inc_min`/`inc_sec`/`sec_tick` is high in any cycle.

## Timing
- Synchronizer: 2 cycles.
- Debounced level updates on the second agreeing `samp`. Debounce latency is therefore 2 sample periods.
- `mode` and `inc_*` are registered and change/assert in the cycle after the debounced level rises.
- Every pulse is exactly one cycle wide.
- First `sec_tick` after entering RUN (or after reset): TICK_DIV cycles after the cycle `mode` becomes 0.
- Tick spacing is exactly TICK_DIV cycles.
- `clr` asserted mid-operation: on the next edge all state returns to reset values, regardless of button levels.

## Test plan
Bench parameters: TICK_DIV=10, DEB_BITS=2, REP_DLY=4, REP_RATE=2.
- Release `clr`, inputs low -> `mode`=0, `blink`=1, `sec_tick` at cycles 10, 20, 30 after reset, no `inc_*`.
- `btn_mode` bounce (1-cycle glitch), then steady high for 3 samples -> exactly one `mode` step 0→1, and `blink` toggles every 64 cycles.
- In SET_MIN, `btn_inc` held steady for 12 samples -> `inc_min` fires on press, then at samples 4, 6, 8, 10 after the debounced rise; no `inc_hr`/`inc_sec`.
- Four clean `btn_mode` presses -> `mode` 1, 2, 3, 0; the first `sec_tick` comes 10 cycles after return to 0, with no tick while in SET states.
- `btn_mode` and `btn_inc` pressed in the same cycle in SET_HR -> `mode`=2, no `inc_hr`.
- `clr` pulsed while in SET_SEC with `btn_inc` held -> `mode`=0, all pulses 0, and no `inc_*` after release until a fresh press in a SET state.
